// File: rtl/camellia_host_pkg.sv
// rtl/camellia_host_pkg.sv - shared types and constants for the Camellia host interface
package camellia_host_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_KEY  = 2'd1,
        ST_DATA = 2'd2,
        ST_WAIT = 2'd3
    } state_e;

    localparam int DEFAULT_TIMEOUT = 1024;

    localparam logic [3:0] ADDR_KEY_LAST   = 4'd7;
    localparam logic [3:0] ADDR_DATA_FIRST = 4'd8;
    localparam logic [3:0] ADDR_DATA_LAST  = 4'd11;
    localparam logic [3:0] ADDR_CONFIG     = 4'd12;

endpackage

// File: rtl/camellia_host_if_if.sv
// rtl/camellia_host_if_if.sv - core-side handshake bundle between host interface and Camellia core
interface camellia_host_if_if;

    logic [127:0] cam_data_in;
    logic [255:0] cam_key;
    logic [1:0]   cam_k_len;
    logic         cam_enc_dec;
    logic         cam_data_rdy;
    logic         cam_key_rdy;
    logic [127:0] cam_data_out;
    logic         cam_data_acq;
    logic         cam_key_acq;
    logic         cam_output_rdy;

    modport master (
        output cam_data_in, cam_key, cam_k_len, cam_enc_dec, cam_data_rdy, cam_key_rdy,
        input  cam_data_out, cam_data_acq, cam_key_acq, cam_output_rdy
    );

    modport slave (
        input  cam_data_in, cam_key, cam_k_len, cam_enc_dec, cam_data_rdy, cam_key_rdy,
        output cam_data_out, cam_data_acq, cam_key_acq, cam_output_rdy
    );

endinterface

// File: rtl/camellia_host_wdog.sv
// rtl/camellia_host_wdog.sv - handshake watchdog counter, expires at TIMEOUT-1
module camellia_host_wdog
    import camellia_host_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT) + 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign expired = (cnt_q == CW'(TIMEOUT - 1));

    // Holds at the expiry value so a late exit cannot wrap and re-arm.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/camellia_host_if.sv
// rtl/camellia_host_if.sv - host register file and key/data/result handshake FSM for a Camellia core
module camellia_host_if
    import camellia_host_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [3:0]         wr_addr,
    input  logic [31:0]        wr_data,
    input  logic               start,
    input  logic [1:0]         rd_addr,
    output logic [31:0]        rd_data,
    output logic               busy,
    output logic               done,
    output logic               err,
    camellia_host_if_if.master cam
);

    state_e        state_q, state_d;
    logic [255:0]  key_q, key_d;
    logic [127:0]  data_q, data_d;
    logic [127:0]  result_q, result_d;
    logic [1:0]    k_len_q, k_len_d;
    logic          enc_dec_q, enc_dec_d;
    logic          key_dirty_q, key_dirty_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          key_rdy_q, key_rdy_d;
    logic          data_rdy_q, data_rdy_d;
    logic          host_wr, key_wr, data_wr, cfg_wr;
    logic          wdog_expired;

    assign host_wr = wr_en && (state_q == ST_IDLE);
    assign key_wr  = host_wr && (wr_addr <= ADDR_KEY_LAST);
    assign data_wr = host_wr && (wr_addr >= ADDR_DATA_FIRST) && (wr_addr <= ADDR_DATA_LAST);
    assign cfg_wr  = host_wr && (wr_addr == ADDR_CONFIG);

    always_comb begin
        state_d     = state_q;
        key_d       = key_q;
        data_d      = data_q;
        result_d    = result_q;
        k_len_d     = k_len_q;
        enc_dec_d   = enc_dec_q;
        key_dirty_d = key_dirty_q;
        err_d       = err_q;
        done_d      = 1'b0;

        if (key_wr) key_d[{wr_addr[2:0], 5'd0} +: 32] = wr_data;
        if (data_wr) data_d[{wr_addr[1:0], 5'd0} +: 32] = wr_data;
        if (cfg_wr) begin
            k_len_d   = wr_data[1:0];
            enc_dec_d = wr_data[2];
        end
        if (key_wr || cfg_wr) key_dirty_d = 1'b1;

        // A key write in the same cycle as start must still reach the core.
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    err_d   = 1'b0;
                    state_d = key_dirty_d ? ST_KEY : ST_DATA;
                end
            end
            ST_KEY: begin
                if (cam.cam_key_acq) begin
                    key_dirty_d = 1'b0;
                    state_d     = ST_DATA;
                end else if (wdog_expired) begin
                    err_d       = 1'b1;
                    key_dirty_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (cam.cam_data_acq) begin
                    state_d = ST_WAIT;
                end else if (wdog_expired) begin
                    err_d       = 1'b1;
                    key_dirty_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cam.cam_output_rdy) begin
                    result_d = cam.cam_data_out;
                    done_d   = 1'b1;
                    state_d  = ST_IDLE;
                end else if (wdog_expired) begin
                    err_d       = 1'b1;
                    key_dirty_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        key_rdy_d  = (state_d == ST_KEY);
        data_rdy_d = (state_d == ST_DATA);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            key_q       <= '0;
            data_q      <= '0;
            result_q    <= '0;
            k_len_q     <= '0;
            enc_dec_q   <= 1'b0;
            key_dirty_q <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            key_rdy_q   <= 1'b0;
            data_rdy_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            data_q      <= data_d;
            result_q    <= result_d;
            k_len_q     <= k_len_d;
            enc_dec_q   <= enc_dec_d;
            key_dirty_q <= key_dirty_d;
            done_q      <= done_d;
            err_q       <= err_d;
            key_rdy_q   <= key_rdy_d;
            data_rdy_q  <= data_rdy_d;
        end
    end

    camellia_host_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk     (clk),
        .rst_n   (rst),
        .clr     (state_d != state_q),
        .en      (state_q != ST_IDLE),
        .expired (wdog_expired)
    );

    assign busy             = (state_q != ST_IDLE);
    assign done             = done_q;
    assign err              = err_q;
    assign rd_data          = result_q[{rd_addr, 5'd0} +: 32];
    assign cam.cam_data_in  = data_q;
    assign cam.cam_key      = key_q;
    assign cam.cam_k_len    = k_len_q;
    assign cam.cam_enc_dec  = enc_dec_q;
    assign cam.cam_key_rdy  = key_rdy_q;
    assign cam.cam_data_rdy = data_rdy_q;

endmodule

// File: tb/tb_camellia_host_if.sv
// tb/tb_camellia_host_if.sv - randomized self-checking bench for camellia_host_if
module tb_camellia_host_if;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        start = 1'b0;
    logic [1:0]  rd_addr = '0;
    logic [31:0] rd_data;
    logic        busy, done, err;

    camellia_host_if_if cam ();

    camellia_host_if #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done),
        .err(err), .cam(cam)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: register contents as the host sees them.
    logic [31:0] m_key [8];
    logic [31:0] m_data [4];
    logic [127:0] m_res;
    logic [1:0]  m_klen;
    logic        m_ed;
    bit          m_dirty;

    function automatic void m_reset();
        for (int i = 0; i < 8; i++) m_key[i] = '0;
        for (int i = 0; i < 4; i++) m_data[i] = '0;
        m_res = '0; m_klen = '0; m_ed = 1'b0; m_dirty = 1'b1;
    endfunction

    function automatic void m_write(input logic [3:0] a, input logic [31:0] d);
        if (a < 4'd8) begin
            m_key[a[2:0]] = d; m_dirty = 1'b1;
        end else if (a < 4'd12) begin
            m_data[a[1:0]] = d;
        end else if (a == 4'd12) begin
            m_klen = d[1:0]; m_ed = d[2]; m_dirty = 1'b1;
        end
    endfunction

    function automatic logic [255:0] m_key_flat();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = m_key[i];
        return r;
    endfunction

    function automatic logic [127:0] m_data_flat();
        logic [127:0] r;
        for (int i = 0; i < 4; i++) r[32*i +: 32] = m_data[i];
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic host_write(input logic [3:0] a, input logic [31:0] d);
        wr_addr = a; wr_data = d; wr_en = 1'b1;
        @(posedge clk); #1;
        wr_en = 1'b0;
        m_write(a, d);
    endtask

    task automatic read_result(output logic [127:0] r);
        for (int i = 0; i < 4; i++) begin
            rd_addr = 2'(i); #1;
            r[32*i +: 32] = rd_data;
        end
    endtask

    task automatic clear_core();
        cam.cam_key_acq = 1'b0; cam.cam_data_acq = 1'b0; cam.cam_output_rdy = 1'b0;
    endtask

    // Plays the core: acks each rdy after a delay, then returns dout; reports what it saw.
    task automatic run_op(input int kd, input int dd, input int od, input logic [127:0] dout,
                          input bit cw, input logic [3:0] ca, input logic [31:0] cd,
                          output bit key_phase, output int rdy_lat, output logic [255:0] g_key,
                          output logic [127:0] g_data, output logic [1:0] g_klen, output logic g_ed,
                          output int done_cnt, output bit hung);
        int kc, dc, wc, post;
        key_phase = 0; rdy_lat = -1; done_cnt = 0; hung = 1;
        kc = 0; dc = 0; wc = 0; post = -1;
        g_key = '0; g_data = '0; g_klen = '0; g_ed = 1'b0;
        start = 1'b1; wr_en = cw; wr_addr = ca; wr_data = cd;
        @(posedge clk); #1;
        start = 1'b0; wr_en = 1'b0;
        for (int c = 1; c < 80; c++) begin
            clear_core();
            cam.cam_data_out = rand128();
            if (done) done_cnt++;
            if (post == 0) begin hung = 0; break; end
            if (post > 0) post--;
            if (cam.cam_key_rdy) begin
                if (kc == 0) begin
                    key_phase = 1; if (rdy_lat < 0) rdy_lat = c;
                    g_key = cam.cam_key; g_klen = cam.cam_k_len; g_ed = cam.cam_enc_dec;
                end
                if (kc == kd) cam.cam_key_acq = 1'b1;
                kc++;
            end else if (cam.cam_data_rdy) begin
                if (dc == 0) begin
                    if (rdy_lat < 0) rdy_lat = c;
                    g_data = cam.cam_data_in;
                    if (!key_phase) begin
                        g_key = cam.cam_key; g_klen = cam.cam_k_len; g_ed = cam.cam_enc_dec;
                    end
                end
                if (dc == dd) cam.cam_data_acq = 1'b1;
                dc++;
            end else if (busy && post < 0) begin
                if (wc == od) begin
                    cam.cam_output_rdy = 1'b1; cam.cam_data_out = dout; post = 2;
                end
                wc++;
            end
            @(posedge clk); #1;
        end
        clear_core();
    endtask

    task automatic test_reset();
        logic [127:0] r;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", done); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b exp=0", err); end
        checks++; if ({cam.cam_key_rdy, cam.cam_data_rdy} !== 2'b00) begin failures++; $display("FAIL reset_rdy got=%b exp=00", {cam.cam_key_rdy, cam.cam_data_rdy}); end
        checks++; if (cam.cam_key !== '0 || cam.cam_data_in !== '0) begin failures++; $display("FAIL reset_regs key=%h data=%h exp=0", cam.cam_key, cam.cam_data_in); end
        read_result(r);
        checks++; if (r !== 128'd0) begin failures++; $display("FAIL reset_result got=%h exp=0", r); end
        @(posedge clk); #1;
        rst = 1'b1;
        m_reset();
    endtask

    task automatic test_basic();
        bit kp, hung; int lat, dc; logic [255:0] gk; logic [127:0] gd, r; logic [1:0] gl; logic ge;
        logic [127:0] dout = 128'h0123456789ABCDEF_0123456789ABCDEF;
        for (int i = 0; i < 8; i++) host_write(4'(i), 32'(i));
        for (int i = 0; i < 4; i++) host_write(4'(8 + i), 32'(8 + i));
        host_write(4'd12, 32'h4);
        run_op(2, 2, 2, dout, 0, 4'd0, 32'd0, kp, lat, gk, gd, gl, ge, dc, hung);
        checks++; if (hung !== 1'b0) begin failures++; $display("FAIL basic_hung got=%0b exp=0", hung); end
        checks++; if (kp !== 1'b1) begin failures++; $display("FAIL basic_key_phase got=%0b exp=1", kp); end
        checks++; if (lat != 1) begin failures++; $display("FAIL basic_rdy_latency got=%0d exp=1", lat); end
        checks++; if (gk !== m_key_flat()) begin failures++; $display("FAIL basic_key got=%h exp=%h", gk, m_key_flat()); end
        checks++; if (gd !== m_data_flat()) begin failures++; $display("FAIL basic_data got=%h exp=%h", gd, m_data_flat()); end
        checks++; if ({gl, ge} !== 3'b001) begin failures++; $display("FAIL basic_cfg got=%b exp=001", {gl, ge}); end
        checks++; if (dc != 1) begin failures++; $display("FAIL basic_done_count got=%0d exp=1", dc); end
        m_dirty = 0; m_res = dout;
        read_result(r);
        checks++; if (r !== m_res) begin failures++; $display("FAIL basic_result got=%h exp=%h", r, m_res); end
    endtask

    task automatic test_no_rekey();
        bit kp, hung; int lat, dc; logic [255:0] gk; logic [127:0] gd, r; logic [1:0] gl; logic ge;
        logic [127:0] dout = rand128();
        run_op(0, 3, 1, dout, 0, 4'd0, 32'd0, kp, lat, gk, gd, gl, ge, dc, hung);
        checks++; if (kp !== 1'b0) begin failures++; $display("FAIL norekey_key_phase got=%0b exp=0", kp); end
        checks++; if (lat != 1) begin failures++; $display("FAIL norekey_data_latency got=%0d exp=1", lat); end
        checks++; if (dc != 1 || hung) begin failures++; $display("FAIL norekey_done got=%0d hung=%0b exp=1", dc, hung); end
        m_res = dout;
        read_result(r);
        checks++; if (r !== m_res) begin failures++; $display("FAIL norekey_result got=%h exp=%h", r, m_res); end
    endtask

    task automatic test_config_rekey();
        bit kp, hung; int lat, dc; logic [255:0] gk; logic [127:0] gd; logic [1:0] gl; logic ge;
        host_write(4'd12, $urandom);
        run_op(1, 1, 0, rand128(), 0, 4'd0, 32'd0, kp, lat, gk, gd, gl, ge, dc, hung);
        checks++; if (kp !== 1'b1) begin failures++; $display("FAIL cfg_rekey_phase got=%0b exp=1", kp); end
        checks++; if ({gl, ge} !== {m_klen, m_ed}) begin failures++; $display("FAIL cfg_rekey_cfg got=%b exp=%b", {gl, ge}, {m_klen, m_ed}); end
        checks++; if (dc != 1 || hung) begin failures++; $display("FAIL cfg_rekey_done got=%0d hung=%0b exp=1", dc, hung); end
        m_dirty = 0;
        run_op(0, 0, 0, rand128(), 0, 4'd0, 32'd0, kp, lat, gk, gd, gl, ge, dc, hung);
        checks++; if (kp !== 1'b0) begin failures++; $display("FAIL cfg_rekey_second got=%0b exp=0", kp); end
        m_res = 'x;
    endtask

    task automatic test_busy_ignored();
        logic [127:0] dout = rand128();
        logic [127:0] r;
        start = 1'b1; @(posedge clk); #1; start = 1'b0;
        checks++; if (cam.cam_data_rdy !== 1'b1) begin failures++; $display("FAIL ign_data_rdy got=%0b exp=1", cam.cam_data_rdy); end
        cam.cam_output_rdy = 1'b1; cam.cam_data_out = rand128();
        wr_en = 1'b1; wr_addr = 4'(8 + $urandom_range(0, 3)); wr_data = $urandom;
        @(posedge clk); #1;
        cam.cam_output_rdy = 1'b0; wr_en = 1'b0;
        checks++; if (done !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL ign_output_rdy done=%0b busy=%0b exp done=0 busy=1", done, busy); end
        checks++; if (cam.cam_data_in !== m_data_flat()) begin failures++; $display("FAIL ign_busy_write got=%h exp=%h", cam.cam_data_in, m_data_flat()); end
        cam.cam_data_acq = 1'b1; @(posedge clk); #1; cam.cam_data_acq = 1'b0;
        cam.cam_output_rdy = 1'b1; cam.cam_data_out = dout; @(posedge clk); #1; clear_core();
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL ign_done got=%0b exp=1", done); end
        m_res = dout;
        read_result(r);
        checks++; if (r !== m_res) begin failures++; $display("FAIL ign_result got=%h exp=%h", r, m_res); end
    endtask

    task automatic test_timeout();
        logic [127:0] r;
        logic [127:0] dout = rand128();
        host_write(4'(4'($urandom_range(0, 7))), $urandom);
        start = 1'b1; @(posedge clk); #1; start = 1'b0;
        repeat (15) begin @(posedge clk); #1; end
        checks++; if (err !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL to_early err=%0b busy=%0b exp err=0 busy=1", err, busy); end
        @(posedge clk); #1;
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL to_err got=%0b exp=1", err); end
        checks++; if (busy !== 1'b0 || cam.cam_key_rdy !== 1'b0) begin failures++; $display("FAIL to_idle busy=%0b key_rdy=%0b exp=0", busy, cam.cam_key_rdy); end
        read_result(r);
        checks++; if (r !== m_res) begin failures++; $display("FAIL to_result_kept got=%h exp=%h", r, m_res); end
        // Restart clears err; key_acq landing on the expiry cycle must win.
        start = 1'b1; @(posedge clk); #1; start = 1'b0;
        checks++; if (err !== 1'b0 || cam.cam_key_rdy !== 1'b1) begin failures++; $display("FAIL to_restart err=%0b key_rdy=%0b exp err=0 key_rdy=1", err, cam.cam_key_rdy); end
        repeat (15) begin @(posedge clk); #1; end
        cam.cam_key_acq = 1'b1; @(posedge clk); #1; cam.cam_key_acq = 1'b0;
        checks++; if (err !== 1'b0 || cam.cam_data_rdy !== 1'b1) begin failures++; $display("FAIL to_race err=%0b data_rdy=%0b exp err=0 data_rdy=1", err, cam.cam_data_rdy); end
        cam.cam_data_acq = 1'b1; @(posedge clk); #1; cam.cam_data_acq = 1'b0;
        cam.cam_output_rdy = 1'b1; cam.cam_data_out = dout; @(posedge clk); #1; clear_core();
        checks++; if (done !== 1'b1 || err !== 1'b0) begin failures++; $display("FAIL to_race_done done=%0b err=%0b exp done=1 err=0", done, err); end
        m_dirty = 0; m_res = dout;
    endtask

    task automatic test_random();
        bit kp, hung, cw; int lat, dc; logic [255:0] gk; logic [127:0] gd, r, dout; logic [1:0] gl; logic ge;
        logic [3:0] ca; logic [31:0] cd; bit exp_kp;
        for (int it = 0; it < 10; it++) begin
            for (int w = $urandom_range(0, 3); w > 0; w--) host_write(4'($urandom_range(0, 15)), $urandom);
            cw = 1'($urandom_range(0, 1)); ca = 4'($urandom_range(0, 15)); cd = $urandom;
            if (cw) m_write(ca, cd);
            exp_kp = m_dirty;
            dout = rand128();
            run_op($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4), dout, cw, ca, cd,
                   kp, lat, gk, gd, gl, ge, dc, hung);
            checks++; if (kp !== exp_kp || lat != 1) begin failures++; $display("FAIL rand%0d_phase key=%0b lat=%0d exp key=%0b lat=1", it, kp, lat, exp_kp); end
            checks++; if (gk !== m_key_flat() || {gl, ge} !== {m_klen, m_ed}) begin failures++; $display("FAIL rand%0d_key got=%h cfg=%b exp=%h cfg=%b", it, gk, {gl, ge}, m_key_flat(), {m_klen, m_ed}); end
            checks++; if (gd !== m_data_flat()) begin failures++; $display("FAIL rand%0d_data got=%h exp=%h", it, gd, m_data_flat()); end
            checks++; if (dc != 1 || hung) begin failures++; $display("FAIL rand%0d_done got=%0d hung=%0b exp=1", it, dc, hung); end
            m_dirty = 0; m_res = dout;
            read_result(r);
            checks++; if (r !== m_res) begin failures++; $display("FAIL rand%0d_result got=%h exp=%h", it, r, m_res); end
        end
    endtask

    task automatic test_reset_mid();
        logic [127:0] r;
        host_write(4'd3, $urandom);
        start = 1'b1; @(posedge clk); #1; start = 1'b0;
        #2 rst = 1'b0; #1;
        checks++; if (cam.cam_key_rdy !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rstkey_async key_rdy=%0b busy=%0b exp=0", cam.cam_key_rdy, busy); end
        @(posedge clk); #1; rst = 1'b1; m_reset();
        host_write(4'd9, $urandom);
        start = 1'b1; @(posedge clk); #1; start = 1'b0;
        cam.cam_key_acq = 1'b1; @(posedge clk); #1; cam.cam_key_acq = 1'b0;
        cam.cam_data_acq = 1'b1; @(posedge clk); #1; cam.cam_data_acq = 1'b0;
        checks++; if (busy !== 1'b1 || cam.cam_data_rdy !== 1'b0) begin failures++; $display("FAIL rstwait_in_wait busy=%0b data_rdy=%0b exp busy=1 data_rdy=0", busy, cam.cam_data_rdy); end
        rst = 1'b0; #1;
        m_reset();
        checks++; if ({busy, done, err, cam.cam_key_rdy, cam.cam_data_rdy} !== 5'b0) begin failures++; $display("FAIL rstwait_outputs got=%b exp=00000", {busy, done, err, cam.cam_key_rdy, cam.cam_data_rdy}); end
        checks++; if (cam.cam_data_in !== m_data_flat() || cam.cam_key !== m_key_flat()) begin failures++; $display("FAIL rstwait_regs data=%h exp=%h", cam.cam_data_in, m_data_flat()); end
        read_result(r);
        checks++; if (r !== m_res) begin failures++; $display("FAIL rstwait_result got=%h exp=%h", r, m_res); end
        @(posedge clk); #1; rst = 1'b1;
    endtask

    initial begin
        cam.cam_data_out = '0;
        clear_core();
        m_reset();
        test_reset();
        test_basic();
        test_no_rekey();
        test_config_rekey();
        test_busy_ignored();
        test_timeout();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench time limit");
    end

endmodule
